// File: rtl/dsi_link_sequencer.sv
// Sequences one D-PHY HS burst: clock lane up, data lanes up, stream words,
// data lanes down, clock lane down. Bytes of each word are spread one per lane.
module dsi_link_sequencer #(
    parameter int LANES    = 4,
    parameter int CLK_PRE  = 8,
    parameter int CLK_POST = 8
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [8*LANES-1:0]   s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 clk_start_rqst,
    output logic                 clk_fin_rqst,
    input  logic                 clk_active,
    output logic [LANES-1:0]     ln_start_rqst,
    output logic [LANES-1:0]     ln_fin_rqst,
    output logic [8*LANES-1:0]   ln_data,
    input  logic [LANES-1:0]     ln_data_rqst,
    input  logic [LANES-1:0]     ln_active,
    output logic                 busy,
    output logic                 underflow
);
    localparam int CNT_MAX = (CLK_PRE > CLK_POST) ? CLK_PRE : CLK_POST;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(CLK_PRE - 1);
    localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(CLK_POST - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLK_START = 3'd1,
        ST_CLK_PRE   = 3'd2,
        ST_LN_START  = 3'd3,
        ST_LN_SEND   = 3'd4,
        ST_LN_FIN    = 3'd5,
        ST_CLK_POST  = 3'd6,
        ST_CLK_FIN   = 3'd7
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [8*LANES-1:0]    ln_data_r;
    logic                  underflow_r;
    logic                  cnt_zero_s;
    logic                  all_rqst_s;
    logic                  accept_s;
    logic                  underrun_s;

    // Only a request raised on every lane counts; partial requests are ignored.
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
    assign all_rqst_s = &ln_data_rqst;
    assign accept_s   = (state_r == ST_LN_SEND) && all_rqst_s && s_valid;
    assign underrun_s = (state_r == ST_LN_SEND) && all_rqst_s && !s_valid;

    // State register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:      if (tx_start) state_s = ST_CLK_START; else state_s = ST_IDLE;
            ST_CLK_START: if (clk_active) state_s = ST_CLK_PRE; else state_s = ST_CLK_START;
            ST_CLK_PRE:   if (cnt_zero_s) state_s = ST_LN_START; else state_s = ST_CLK_PRE;
            ST_LN_START:  if (&ln_active) state_s = ST_LN_SEND; else state_s = ST_LN_START;
            ST_LN_SEND:   if (accept_s && s_last) state_s = ST_LN_FIN; else state_s = ST_LN_SEND;
            ST_LN_FIN:    if (~|ln_active) state_s = ST_CLK_POST; else state_s = ST_LN_FIN;
            ST_CLK_POST:  if (cnt_zero_s) state_s = ST_CLK_FIN; else state_s = ST_CLK_POST;
            ST_CLK_FIN:   if (!clk_active) state_s = ST_IDLE; else state_s = ST_CLK_FIN;
            default:      state_s = ST_IDLE;
        endcase
    end

    // Dwell counter: loaded on entry to the timed states, saturates at zero
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_CLK_START && state_s == ST_CLK_PRE) begin
            cnt_r <= PRE_LOAD;
        end else if (state_r == ST_LN_FIN && state_s == ST_CLK_POST) begin
            cnt_r <= POST_LOAD;
        end else if ((state_r == ST_CLK_PRE || state_r == ST_CLK_POST) && !cnt_zero_s) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Lane byte register and underrun pulse; an underrun sends zero bytes
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ln_data_r   <= {(8*LANES){1'b0}};
            underflow_r <= 1'b0;
        end else if (accept_s) begin
            ln_data_r   <= s_data;
            underflow_r <= 1'b0;
        end else if (underrun_s) begin
            ln_data_r   <= {(8*LANES){1'b0}};
            underflow_r <= 1'b1;
        end else begin
            ln_data_r   <= ln_data_r;
            underflow_r <= 1'b0;
        end
    end

    // Output decode; requests are also interlocked against live lane status
    always_comb begin
        s_ready        = 1'b0;
        clk_start_rqst = 1'b0;
        clk_fin_rqst   = 1'b0;
        ln_start_rqst  = {LANES{1'b0}};
        ln_fin_rqst    = {LANES{1'b0}};
        busy           = (state_r != ST_IDLE);
        case (state_r)
            ST_CLK_START: clk_start_rqst = 1'b1;
            ST_LN_START:  ln_start_rqst  = {LANES{clk_active}};
            ST_LN_SEND:   s_ready        = all_rqst_s;
            ST_LN_FIN:    ln_fin_rqst    = {LANES{1'b1}};
            ST_CLK_FIN:   clk_fin_rqst   = ~|ln_active;
            default:      busy           = (state_r != ST_IDLE);
        endcase
    end

    assign ln_data   = ln_data_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_dsi_link_sequencer.sv
// Randomized bench for dsi_link_sequencer: the bench plays the D-PHY lanes and
// predicts every burst from the sequencing rules (dwell times, data stream).
module tb_dsi_link_sequencer;
    localparam int LANES    = 4;
    localparam int CLK_PRE  = 8;
    localparam int CLK_POST = 8;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        clk_start_rqst;
    logic        clk_fin_rqst;
    logic        clk_active = 1'b0;
    logic [3:0]  ln_start_rqst;
    logic [3:0]  ln_fin_rqst;
    logic [31:0] ln_data;
    logic [3:0]  ln_data_rqst = 4'h0;
    logic [3:0]  ln_active = 4'h0;
    logic        busy;
    logic        underflow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] words [0:15];
    logic [31:0] exp_ln_data = 32'h0;
    logic [7:0]  lane0_q [$];
    int          uf_obs = 0;

    dsi_link_sequencer #(.LANES(LANES), .CLK_PRE(CLK_PRE), .CLK_POST(CLK_POST)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .tx_start(tx_start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .clk_start_rqst(clk_start_rqst), .clk_fin_rqst(clk_fin_rqst), .clk_active(clk_active),
        .ln_start_rqst(ln_start_rqst), .ln_fin_rqst(ln_fin_rqst), .ln_data(ln_data),
        .ln_data_rqst(ln_data_rqst), .ln_active(ln_active), .busy(busy), .underflow(underflow)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({busy, s_ready, clk_start_rqst, clk_fin_rqst, ln_start_rqst, ln_fin_rqst, ln_data, underflow} !== 45'h0) begin
                miscompares++;
                $display("FAIL reset_outputs: busy=%b ln_data=%h requests=%b%b%h%h expected all 0",
                         busy, ln_data, clk_start_rqst, clk_fin_rqst, ln_start_rqst, ln_fin_rqst);
            end
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy=%b expected 0", busy);
        end
    endtask

    // tx_start, clock lane handshake, CLK_PRE dwell, data-lane start
    task automatic do_open(input int clk_delay, input int act_delay);
        int c;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        vectors++;
        if (clk_start_rqst !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL open_clk_start: clk_start_rqst=%b busy=%b expected 1 1", clk_start_rqst, busy);
        end
        for (int i = 0; i < clk_delay; i++) begin
            tick();
            vectors++;
            if (clk_start_rqst !== 1'b1 || ln_start_rqst !== 4'h0) begin
                miscompares++;
                $display("FAIL clk_wait: clk_start_rqst=%b ln_start_rqst=%h expected 1 0", clk_start_rqst, ln_start_rqst);
            end
        end
        clk_active = 1'b1;
        c = 0;
        do begin
            tick();
            c++;
        end while (ln_start_rqst !== 4'hF && c < 40);
        vectors++;
        if (c != CLK_PRE + 1) begin
            miscompares++;
            $display("FAIL clk_pre_len: ln_start_rqst after %0d samples, expected %0d", c, CLK_PRE + 1);
        end
        for (int i = 0; i < act_delay; i++) begin
            tick();
            vectors++;
            if (ln_start_rqst !== 4'hF) begin
                miscompares++;
                $display("FAIL ln_start_hold: ln_start_rqst=%h expected f", ln_start_rqst);
            end
        end
        ln_active = 4'hF;
        tick();
        vectors++;
        if (ln_start_rqst !== 4'h0 || busy !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL enter_send: ln_start_rqst=%h busy=%b s_ready=%b expected 0 1 0", ln_start_rqst, busy, s_ready);
        end
    endtask

    // Stream words; mode 0 random, 1 clean, 2 two forced underruns before word 1
    task automatic do_send(input int nwords, input int mode, input int tx_inject);
        int          idx = 0;
        int          cyc = 0;
        int          gaps = 0;
        bit          done = 1'b0;
        bit          acc;
        bit          uf;
        bit          last;
        logic [3:0]  req;
        logic        valid;
        int          r;
        while (!done && cyc < 400) begin
            if (mode == 0) begin
                r = $urandom_range(0, 3);
                req = (r == 3) ? 4'h0 : (r == 2) ? 4'($urandom_range(1, 14)) : 4'hF;
                valid = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                req = 4'hF;
                valid = !(idx == 1 && gaps < 2);
                if (!valid) gaps++;
            end else begin
                req = 4'hF;
                valid = 1'b1;
            end
            ln_data_rqst = req;
            s_valid = valid;
            s_data = valid ? words[idx] : $urandom;
            s_last = valid ? (idx == nwords - 1) : 1'($urandom_range(0, 1));
            tx_start = (cyc == tx_inject);
            #1;
            vectors++;
            if (s_ready !== (req == 4'hF)) begin
                miscompares++;
                $display("FAIL s_ready: got %b with ln_data_rqst=%h expected %b", s_ready, req, req == 4'hF);
            end
            acc = valid && (req == 4'hF);
            uf = !valid && (req == 4'hF);
            last = acc && (idx == nwords - 1);
            if (acc) begin
                exp_ln_data = words[idx];
                idx++;
            end else if (uf) begin
                exp_ln_data = 32'h0;
            end
            tick();
            tx_start = 1'b0;
            if (underflow === 1'b1) uf_obs++;
            if (acc) lane0_q.push_back(ln_data[7:0]);
            vectors++;
            if (ln_data !== exp_ln_data || underflow !== uf || ln_fin_rqst !== (last ? 4'hF : 4'h0)) begin
                miscompares++;
                $display("FAIL send_cycle: ln_data=%h underflow=%b ln_fin_rqst=%h expected %h %b %h",
                         ln_data, underflow, ln_fin_rqst, exp_ln_data, uf, last ? 4'hF : 4'h0);
            end
            done = last;
            cyc++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: %0d of %0d words accepted, expected all", idx, nwords);
        end
        ln_data_rqst = 4'hF;
        s_valid = 1'b1;
        #1;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL s_ready_fin: got %b expected 0", s_ready);
        end
        ln_data_rqst = 4'h0;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // Data lanes drop (lane 2 trails by skew), CLK_POST dwell, clock lane stop
    task automatic do_close(input int skew);
        int c;
        int w;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) begin
            tick();
            vectors++;
            if (ln_fin_rqst !== 4'hF || clk_fin_rqst !== 1'b0) begin
                miscompares++;
                $display("FAIL fin_hold: ln_fin_rqst=%h clk_fin_rqst=%b expected f 0", ln_fin_rqst, clk_fin_rqst);
            end
        end
        if (skew > 0) begin
            ln_active = 4'b0100;
            for (int i = 0; i < skew; i++) begin
                tick();
                vectors++;
                if (ln_fin_rqst !== 4'hF || clk_fin_rqst !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fin_skew: ln_fin_rqst=%h clk_fin_rqst=%b expected f 0", ln_fin_rqst, clk_fin_rqst);
                end
            end
        end
        ln_active = 4'h0;
        c = 0;
        do begin
            tick();
            c++;
            if (c == 1) begin
                vectors++;
                if (ln_fin_rqst !== 4'h0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL enter_post: ln_fin_rqst=%h busy=%b expected 0 1", ln_fin_rqst, busy);
                end
            end
        end while (clk_fin_rqst !== 1'b1 && c < 40);
        vectors++;
        if (c != CLK_POST + 1) begin
            miscompares++;
            $display("FAIL clk_post_len: clk_fin_rqst after %0d samples, expected %0d", c, CLK_POST + 1);
        end
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) begin
            tick();
            vectors++;
            if (clk_fin_rqst !== 1'b1) begin
                miscompares++;
                $display("FAIL clk_fin_hold: clk_fin_rqst=%b expected 1", clk_fin_rqst);
            end
        end
        clk_active = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || clk_fin_rqst !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_idle: busy=%b clk_fin_rqst=%b expected 0 0", busy, clk_fin_rqst);
        end
    endtask

    task automatic test_basic_burst();
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        lane0_q.delete();
        do_open(3, 1);
        do_send(3, 1, -1);
        do_close(0);
        vectors++;
        if (lane0_q.size() != 3 || lane0_q[0] !== 8'h00 || lane0_q[1] !== 8'h04 || lane0_q[2] !== 8'h08) begin
            miscompares++;
            $display("FAIL lane0_order: got %0d bytes, expected 00 04 08", lane0_q.size());
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        uf_obs = 0;
        do_open(1, 0);
        do_send(4, 2, -1);
        do_close(2);
        vectors++;
        if (uf_obs != 2) begin
            miscompares++;
            $display("FAIL underflow_count: got %0d pulses expected 2", uf_obs);
        end
    endtask

    task automatic test_fin_skew();
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_open(0, 2);
        do_send(2, 1, -1);
        do_close(5);
    endtask

    task automatic test_tx_ignored();
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        do_open(2, 0);
        do_send(5, 1, 2);
        do_close(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || clk_start_rqst !== 1'b0) begin
                miscompares++;
                $display("FAIL tx_ignored: busy=%b clk_start_rqst=%b expected 0 0", busy, clk_start_rqst);
            end
        end
    endtask

    task automatic test_one_word();
        words[0] = $urandom;
        do_open(0, 0);
        do_send(1, 1, -1);
        do_close(0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        do_open(1, 1);
        ln_data_rqst = 4'hF;
        s_valid = 1'b1;
        s_data = words[0];
        tick();
        s_data = words[1];
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, s_ready, clk_start_rqst, clk_fin_rqst, ln_start_rqst, ln_fin_rqst, ln_data, underflow} !== 45'h0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b s_ready=%b ln_data=%h expected all 0", busy, s_ready, ln_data);
        end
        ln_data_rqst = 4'h0;
        s_valid = 1'b0;
        ln_active = 4'h0;
        clk_active = 1'b0;
        exp_ln_data = 32'h0;
        tick();
        rst_n = 1'b1;
        tick();
        do_open(2, 1);
        do_send(4, 0, -1);
        do_close(3);
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            do_open($urandom_range(0, 5), $urandom_range(0, 3));
            do_send(n, 0, (b == 3) ? 1 : -1);
            do_close($urandom_range(0, 6));
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_underflow();
        test_fin_skew();
        test_tx_ignored();
        test_one_word();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
